// File: rtl/bp_dmem.sv
// Data memory for the basic processor: 1-cycle registered read, write-first, and a clear sweep after reset.
// Optional BP_DMEM_MMIO_EN maps the top address onto the io_out register.
module bp_dmem #(
  parameter int unsigned         DATA_W    = 16,
  parameter int unsigned         ADDR_W    = 8,
  parameter logic [DATA_W-1:0]   CLEAR_VAL = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_data_w,
  input  logic              dm_we,
  output logic [DATA_W-1:0] dm_data_r,
  output logic              busy
`ifdef BP_DMEM_MMIO_EN
  , output logic [DATA_W-1:0] io_out
`endif
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {CLEAR, READY} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     clr_addr_q, clr_addr_d;
  logic [DATA_W-1:0]   dm_data_r_q, dm_data_r_d;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   rd_word;

`ifdef BP_DMEM_MMIO_EN
  logic                io_sel;
  logic [DATA_W-1:0]   io_out_q, io_out_d;

  assign io_sel = (dm_addr == {ADDR_W{1'b1}});
  assign io_out = io_out_q;
`endif

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    dm_data_r_d = '0;
    mem_we      = 1'b0;
    mem_waddr   = dm_addr;
    mem_wdata   = dm_data_w;
    rd_word     = mem[dm_addr];
`ifdef BP_DMEM_MMIO_EN
    io_out_d    = io_out_q;
    if (io_sel) rd_word = io_out_q;
`endif
    case (state_q)
      CLEAR: begin
        // One word per cycle; the extra MSB of clr_addr marks the end of the sweep.
        mem_we     = 1'b1;
        mem_waddr  = clr_addr_q[ADDR_W-1:0];
        mem_wdata  = CLEAR_VAL;
        clr_addr_d = clr_addr_q + (ADDR_W+1)'(1);
        if (clr_addr_d[ADDR_W]) state_d = READY;
      end
      READY: begin
        dm_data_r_d = dm_we ? dm_data_w : rd_word;
        if (dm_we) begin
`ifdef BP_DMEM_MMIO_EN
          if (io_sel) io_out_d = dm_data_w;
          else        mem_we   = 1'b1;
`else
          mem_we = 1'b1;
`endif
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      clr_addr_q  <= '0;
      dm_data_r_q <= '0;
`ifdef BP_DMEM_MMIO_EN
      io_out_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      dm_data_r_q <= dm_data_r_d;
`ifdef BP_DMEM_MMIO_EN
      io_out_q    <= io_out_d;
`endif
    end
  end

  // Storage has no reset; reset drops any pending write.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign dm_data_r = dm_data_r_q;
  assign busy      = (state_q == CLEAR);

endmodule

// File: tb/tb_bp_dmem.sv
// Directed bench for bp_dmem: reset sweep, read/write, write-first, busy gating, mid-sweep reset, optional MMIO.
module tb_bp_dmem;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  dm_addr = '0;
  logic [15:0] dm_data_w = '0;
  logic        dm_we = 1'b0;
  logic [15:0] dm_data_r;
  logic        busy;
`ifdef BP_DMEM_MMIO_EN
  logic [15:0] io_out;
`endif

  int n_cmp = 0;
  int n_err = 0;

  bp_dmem dut (
    .clk       (clk),
    .rst       (rst),
    .dm_addr   (dm_addr),
    .dm_data_w (dm_data_w),
    .dm_we     (dm_we),
    .dm_data_r (dm_data_r),
    .busy      (busy)
`ifdef BP_DMEM_MMIO_EN
    , .io_out  (io_out)
`endif
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycles until busy drops, bounded at 400.
  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 400) begin
      tick();
      cycles++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; dm_we = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic write_word(input logic [7:0] a, input logic [15:0] d);
    dm_we = 1'b1; dm_addr = a; dm_data_w = d;
    tick();
    dm_we = 1'b0;
  endtask

  task automatic test_reset();
    int cyc;
    rst = 1'b1;
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy got %b want 1", busy); end
    n_cmp++; if (dm_data_r !== 16'h0000) begin n_err++; $display("FAIL reset_rdata got %h want 0000", dm_data_r); end
    rst = 1'b0;
    wait_ready(cyc);
    n_cmp++; if (cyc !== 256) begin n_err++; $display("FAIL sweep_len got %0d want 256", cyc); end
    dm_addr = 8'h10;
    tick();
    n_cmp++; if (dm_data_r !== 16'h0000) begin n_err++; $display("FAIL cleared_0x10 got %h want 0000", dm_data_r); end
  endtask

  task automatic test_write_read();
    write_word(8'h03, 16'hA5A5);
    dm_addr = 8'h03;
    tick();
    n_cmp++; if (dm_data_r !== 16'hA5A5) begin n_err++; $display("FAIL wr_rd_0x03 got %h want a5a5", dm_data_r); end
  endtask

  task automatic test_read_during_write();
    write_word(8'h20, 16'h1234);
    n_cmp++; if (dm_data_r !== 16'h1234) begin n_err++; $display("FAIL write_first got %h want 1234", dm_data_r); end
    dm_addr = 8'h21;
    tick();
    n_cmp++; if (dm_data_r !== 16'h0000) begin n_err++; $display("FAIL neighbour_0x21 got %h want 0000", dm_data_r); end
    dm_addr = 8'h20;
    tick();
    n_cmp++; if (dm_data_r !== 16'h1234) begin n_err++; $display("FAIL stored_0x20 got %h want 1234", dm_data_r); end
  endtask

  task automatic test_write_while_busy();
    int cyc;
    do_reset();
    repeat (4) tick();
    write_word(8'h80, 16'hFFFF);
    n_cmp++; if (dm_data_r !== 16'h0000) begin n_err++; $display("FAIL busy_rdata got %h want 0000", dm_data_r); end
    // 0x02 was already swept, so only the busy gate keeps it clear.
    write_word(8'h02, 16'hBEEF);
    wait_ready(cyc);
    n_cmp++; if (cyc !== 250) begin n_err++; $display("FAIL busy_remaining got %0d want 250", cyc); end
    dm_addr = 8'h80;
    tick();
    n_cmp++; if (dm_data_r !== 16'h0000) begin n_err++; $display("FAIL busy_wr_0x80 got %h want 0000", dm_data_r); end
    dm_addr = 8'h02;
    tick();
    n_cmp++; if (dm_data_r !== 16'h0000) begin n_err++; $display("FAIL busy_wr_0x02 got %h want 0000", dm_data_r); end
  endtask

  task automatic test_reset_mid_sweep();
    int cyc;
    write_word(8'h40, 16'hBEEF);
    dm_addr = 8'h40;
    tick();
    n_cmp++; if (dm_data_r !== 16'hBEEF) begin n_err++; $display("FAIL pre_rst_0x40 got %h want beef", dm_data_r); end
    do_reset();
    repeat (99) tick();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_sweep_busy got %b want 1", busy); end
    do_reset();
    wait_ready(cyc);
    n_cmp++; if (cyc !== 256) begin n_err++; $display("FAIL restart_len got %0d want 256", cyc); end
    dm_addr = 8'h40;
    tick();
    n_cmp++; if (dm_data_r !== 16'h0000) begin n_err++; $display("FAIL post_rst_0x40 got %h want 0000", dm_data_r); end
  endtask

  task automatic test_rst_beats_write();
    int cyc;
    rst = 1'b1; dm_we = 1'b1; dm_addr = 8'h50; dm_data_w = 16'h7777;
    tick();
    rst = 1'b0; dm_we = 1'b0;
    n_cmp++; if (dm_data_r !== 16'h0000) begin n_err++; $display("FAIL rst_we_rdata got %h want 0000", dm_data_r); end
    wait_ready(cyc);
    n_cmp++; if (cyc !== 256) begin n_err++; $display("FAIL rst_we_len got %0d want 256", cyc); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [4];
    vals[0] = 16'h0001; vals[1] = 16'h8000; vals[2] = 16'hCAFE; vals[3] = 16'h5555;
    for (int i = 0; i < 4; i++) begin
      dm_we = 1'b1; dm_addr = 8'h10 + 8'(i); dm_data_w = vals[i];
      tick();
    end
    dm_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dm_addr = 8'h10 + 8'(i);
      tick();
      n_cmp++;
      if (dm_data_r !== vals[i]) begin
        n_err++; $display("FAIL b2b_%0d got %h want %h", i, dm_data_r, vals[i]);
      end
    end
  endtask

  task automatic test_top_address();
`ifdef BP_DMEM_MMIO_EN
    write_word(8'hFF, 16'h00C3);
    n_cmp++; if (io_out !== 16'h00C3) begin n_err++; $display("FAIL io_out_set got %h want 00c3", io_out); end
    n_cmp++; if (dm_data_r !== 16'h00C3) begin n_err++; $display("FAIL io_wfirst got %h want 00c3", dm_data_r); end
    dm_addr = 8'hFF;
    tick();
    n_cmp++; if (dm_data_r !== 16'h00C3) begin n_err++; $display("FAIL io_read got %h want 00c3", dm_data_r); end
    do_reset();
    n_cmp++; if (io_out !== 16'h0000) begin n_err++; $display("FAIL io_rst got %h want 0000", io_out); end
`else
    write_word(8'hFF, 16'h5A5A);
    dm_addr = 8'hFF;
    tick();
    n_cmp++; if (dm_data_r !== 16'h5A5A) begin n_err++; $display("FAIL top_ram got %h want 5a5a", dm_data_r); end
    dm_addr = 8'hFE;
    tick();
    n_cmp++; if (dm_data_r !== 16'h0000) begin n_err++; $display("FAIL below_top got %h want 0000", dm_data_r); end
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_read_during_write();
    test_back_to_back();
    test_top_address();
    test_write_while_busy();
    test_reset_mid_sweep();
    test_rst_beats_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
